// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter_if
// Description : Producer handshake bus and FIFO write port of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_write_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;
    logic [15:0]                   xfer_count;

    // master: producers plus FIFO status; slave: the arbiter itself
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, w_en, data_in, grant_valid, grant_id, xfer_count
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, w_en, data_in, grant_valid, grant_id, xfer_count
    );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fifo_write_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [7:0]    c_BURST_LEN = 8'(BURST_LEN);
    localparam logic [ID_W:0] c_NUM_REQ   = (ID_W+1)'(NUM_REQ);

    state_t              r_state_q, w_state_d;
    logic [ID_W-1:0]     r_owner_q, w_owner_d;
    logic [ID_W-1:0]     r_rr_ptr_q, w_rr_ptr_d;
    logic [7:0]          r_burst_cnt_q, w_burst_cnt_d;
    logic [15:0]         r_xfer_count_q, w_xfer_count_d;

    logic [ID_W-1:0]       w_sel;
    logic                  w_grant_valid;
    logic                  w_xfer;
    logic [NUM_REQ-1:0]    w_ready;
    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

    // (ptr + k) modulo NUM_REQ, for k in 0..NUM_REQ-1
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] ptr, input int k);
        logic [ID_W:0] s;
        s = {1'b0, ptr} + (ID_W+1)'(k);
        if (s >= c_NUM_REQ) begin
            s = s - c_NUM_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Descending scan so the last hit, i.e. the closest to rr_ptr, wins
    always_comb begin
        w_sel         = r_owner_q;
        w_grant_valid = bus.req_valid[r_owner_q];
        if (r_state_q == S_IDLE) begin
            w_sel         = r_rr_ptr_q;
            w_grant_valid = |bus.req_valid;
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[wrap_add(r_rr_ptr_q, k)]) begin
                    w_sel = wrap_add(r_rr_ptr_q, k);
                end
            end
        end
    end

    assign w_xfer = w_grant_valid & ~bus.fifo_full;

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == ID_W'(i)) begin
                w_ready[i] = 1'b1;
            end
        end
    end

    // Outputs are gated by rst_n so they clear the moment reset asserts
    assign bus.w_en        = rst_n & w_xfer;
    assign bus.req_ready   = w_ready & {NUM_REQ{rst_n & w_xfer}};
    assign bus.grant_valid = rst_n & w_grant_valid;
    assign bus.grant_id    = (rst_n && w_grant_valid) ? w_sel : '0;
    assign bus.data_in     = (rst_n && w_grant_valid) ? w_words[w_sel] : '0;
    assign bus.xfer_count  = r_xfer_count_q;

    always_comb begin
        w_state_d      = r_state_q;
        w_owner_d      = r_owner_q;
        w_rr_ptr_d     = r_rr_ptr_q;
        w_burst_cnt_d  = r_burst_cnt_q;
        w_xfer_count_d = r_xfer_count_q + 16'(w_xfer);
        case (r_state_q)
            S_IDLE: begin
                if (w_xfer) begin
                    if (BURST_LEN == 1) begin
                        w_rr_ptr_d = wrap_add(w_sel, 1);
                    end else begin
                        w_state_d     = S_BURST;
                        w_owner_d     = w_sel;
                        w_burst_cnt_d = 8'd1;
                    end
                end
            end
            S_BURST: begin
                if (w_xfer) begin
                    if (r_burst_cnt_q + 8'd1 == c_BURST_LEN) begin
                        w_state_d  = S_IDLE;
                        w_rr_ptr_d = wrap_add(r_owner_q, 1);
                    end else begin
                        w_burst_cnt_d = r_burst_cnt_q + 8'd1;
                    end
                end else if (!bus.req_valid[r_owner_q]) begin
                    // owner withdrew: burst ends, this cycle is a bubble
                    w_state_d  = S_IDLE;
                    w_rr_ptr_d = wrap_add(r_owner_q, 1);
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q      <= S_IDLE;
            r_owner_q      <= '0;
            r_rr_ptr_q     <= '0;
            r_burst_cnt_q  <= '0;
            r_xfer_count_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_owner_q      <= w_owner_d;
            r_rr_ptr_q     <= w_rr_ptr_d;
            r_burst_cnt_q  <= w_burst_cnt_d;
            r_xfer_count_q <= w_xfer_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Self-checking bench for fifo_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BL = 4;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [NR-1:0] acc_q = '0;
    int            cnt  [NR];
    int            base [NR];
    logic [DW-1:0] q [$];

    // Reference model: current grant holder and words it has been given
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_done  = 0;
    int          m_start = 0;
    logic [15:0] m_count = '0;

    logic [7:0] exp_rr [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                                8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
                                8'h04, 8'h05, 8'h06, 8'h07};

    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) bus ();

    fifo_write_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .BURST_LEN (BL),
        .ID_W      (IW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_data();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            v[i*DW +: DW] = DW'(base[i] + cnt[i]);
        end
        bus.req_data = v;
    endtask

    // Advance one clock; producers whose word was accepted move to the next word
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_q[i]) cnt[i]++;
        end
        set_data();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.fifo_full = 1'b0;
        tick();
        tick();
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        set_data();
        rst_n = 1'b1;
    endtask

    // Compare process: model prediction vs DUT on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy  = 1'b0;
                m_owner = 0;
                m_done  = 0;
                m_start = 0;
                m_count = '0;
                chk("rst w_en",        bus.w_en,        0);
                chk("rst req_ready",   bus.req_ready,   0);
                chk("rst grant_valid", bus.grant_valid, 0);
                chk("rst grant_id",    bus.grant_id,    0);
                chk("rst data_in",     bus.data_in,     0);
                chk("rst xfer_count",  bus.xfer_count,  0);
            end else begin
                int            sel;
                bit            gv;
                bit            xf;
                bit            found;
                logic [DW-1:0] d;
                logic [NR-1:0] rdy;
                sel   = 0;
                found = 1'b0;
                if (!m_busy) begin
                    for (int k = 0; k < NR; k++) begin
                        if (!found && bus.req_valid[(m_start + k) % NR]) begin
                            sel   = (m_start + k) % NR;
                            found = 1'b1;
                        end
                    end
                    gv = found;
                end else begin
                    sel = m_owner;
                    gv  = bus.req_valid[m_owner];
                end
                xf  = gv && !bus.fifo_full;
                d   = gv ? bus.req_data[sel*DW +: DW] : '0;
                rdy = '0;
                if (xf) rdy[sel] = 1'b1;

                chk("w_en",        bus.w_en,        xf);
                chk("req_ready",   bus.req_ready,   rdy);
                chk("grant_valid", bus.grant_valid, gv);
                chk("grant_id",    bus.grant_id,    gv ? sel : 0);
                chk("data_in",     bus.data_in,     d);
                chk("xfer_count",  bus.xfer_count,  m_count);

                if (xf) begin
                    q.push_back(d);
                    m_count = m_count + 16'd1;
                end
                if (!m_busy) begin
                    if (xf) begin
                        if (BL == 1) begin
                            m_start = (sel + 1) % NR;
                        end else begin
                            m_busy  = 1'b1;
                            m_owner = sel;
                            m_done  = 1;
                        end
                    end
                end else if (xf) begin
                    m_done++;
                    if (m_done == BL) begin
                        m_busy  = 1'b0;
                        m_start = (m_owner + 1) % NR;
                    end
                end else if (!bus.req_valid[m_owner]) begin
                    m_busy  = 1'b0;
                    m_start = (m_owner + 1) % NR;
                end
            end
            acc_q = bus.req_ready;
        end
    end

    initial begin
        int s1;
        for (int i = 0; i < NR; i++) begin
            cnt[i]  = 0;
            base[i] = 8'h50 + i;
        end
        bus.req_valid = '1;
        bus.fifo_full = 1'b0;
        set_data();
        tick();
        #1;
        chk("init w_en",        bus.w_en,        0);
        chk("init grant_valid", bus.grant_valid, 0);
        chk("init data_in",     bus.data_in,     0);
        chk("init xfer_count",  bus.xfer_count,  0);

        // Single requester: back-to-back bursts with no bubble
        do_reset();
        base[2]       = 8'h10;
        bus.req_valid = 4'b0100;
        set_data();
        s1 = q.size();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t1 w_en",     bus.w_en,     1);
            chk("t1 grant_id", bus.grant_id, 2);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            chk("t1 fifo word", q[s1 + k], 8'h10 + k);
        end

        // Round robin with all producers valid
        do_reset();
        for (int i = 0; i < NR; i++) base[i] = i * 16;
        bus.req_valid = 4'hF;
        set_data();
        for (int k = 0; k < 20; k++) begin
            #1;
            if (k == 16) chk("t2 xfer_count", bus.xfer_count, 16);
            chk("t2 data_in", bus.data_in, exp_rr[k]);
            tick();
        end

        // Backpressure mid-burst
        do_reset();
        base[1]       = 8'h40;
        base[3]       = 8'h70;
        bus.req_valid = 4'b1010;
        set_data();
        #1; chk("t3 grant_id", bus.grant_id, 1); chk("t3 data_in", bus.data_in, 8'h40); tick();
        #1; chk("t3 data_in", bus.data_in, 8'h41); tick();
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3 full w_en",      bus.w_en,        0);
            chk("t3 full req_ready", bus.req_ready,   0);
            chk("t3 full grant_id",  bus.grant_id,    1);
            chk("t3 full data_in",   bus.data_in,     8'h42);
            tick();
        end
        bus.fifo_full = 1'b0;
        #1; chk("t3 w_en", bus.w_en, 1); chk("t3 data_in", bus.data_in, 8'h42); tick();
        #1; chk("t3 data_in", bus.data_in, 8'h43); tick();
        #1; chk("t3 next grant_id", bus.grant_id, 3); chk("t3 next data_in", bus.data_in, 8'h70); tick();

        // Owner drop: one bubble, then search resumes after the owner
        do_reset();
        base[0]       = 8'h80;
        base[3]       = 8'h90;
        bus.req_valid = 4'b0001;
        set_data();
        #1; chk("t4 grant_id", bus.grant_id, 0); chk("t4 data_in", bus.data_in, 8'h80); tick();
        bus.req_valid = 4'b1000;
        #1; chk("t4 bubble w_en", bus.w_en, 0); chk("t4 bubble grant_valid", bus.grant_valid, 0); tick();
        #1; chk("t4 grant_id", bus.grant_id, 3); chk("t4 w_en", bus.w_en, 1); chk("t4 data_in", bus.data_in, 8'h90); tick();

        // Asynchronous reset in the middle of a burst
        do_reset();
        base[2]       = 8'hA0;
        bus.req_valid = 4'b0100;
        set_data();
        tick();
        tick();
        bus.req_valid = 4'hF;
        #1; chk("t5 grant_id", bus.grant_id, 2); chk("t5 w_en", bus.w_en, 1);
        #1; rst_n = 1'b0;
        #1;
        chk("t5 async w_en",        bus.w_en,        0);
        chk("t5 async req_ready",   bus.req_ready,   0);
        chk("t5 async grant_valid", bus.grant_valid, 0);
        chk("t5 async grant_id",    bus.grant_id,    0);
        chk("t5 async data_in",     bus.data_in,     0);
        chk("t5 async xfer_count",  bus.xfer_count,  0);
        tick();
        tick();
        rst_n = 1'b1;
        #1; chk("t5 restart grant_id", bus.grant_id, 0); chk("t5 restart grant_valid", bus.grant_valid, 1);
        tick();

        // Transfer counter wrap
        do_reset();
        bus.req_valid = 4'hF;
        repeat (65535) tick();
        #1; chk("t6 xfer_count ffff", bus.xfer_count, 16'hFFFF);
        tick();
        #1; chk("t6 xfer_count wrap", bus.xfer_count, 0);
        tick();
        #1; chk("t6 xfer_count one", bus.xfer_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
